// File: rtl/jtframe_ram1_nslots_if.sv
// Bus bundle for jtframe_ram1_nslots: game-core slot ports plus the SDRAM bank command/data port.
// The arbiter uses the slave modport; whatever drives the slots and models the controller uses master.
interface jtframe_ram1_nslots_if #(
    parameter int SDRAMW = 22,
    parameter int NSLOTS = 4,
    parameter int AW     = 22
);
    logic [NSLOTS*AW-1:0] slot_addr;
    logic [NSLOTS-1:0]    slot_cs;
    logic [NSLOTS-1:0]    slot_clr;
    logic [NSLOTS-1:0]    slot_ok;
    logic [NSLOTS*16-1:0] slot_dout;
    logic                 slot0_wen;
    logic [15:0]          slot0_din;
    logic [1:0]           slot0_wrmask;
    logic                 sdram_ack;
    logic                 sdram_rd;
    logic                 sdram_wr;
    logic [SDRAMW-1:0]    sdram_addr;
    logic                 data_rdy;
    logic [15:0]          data_read;
    logic [15:0]          data_write;
    logic [1:0]           sdram_wrmask;

    modport master (
        output slot_addr, slot_cs, slot_clr, slot0_wen, slot0_din, slot0_wrmask,
        output sdram_ack, data_rdy, data_read,
        input  slot_ok, slot_dout, sdram_rd, sdram_wr, sdram_addr, data_write, sdram_wrmask
    );

    modport slave (
        input  slot_addr, slot_cs, slot_clr, slot0_wen, slot0_din, slot0_wrmask,
        input  sdram_ack, data_rdy, data_read,
        output slot_ok, slot_dout, sdram_rd, sdram_wr, sdram_addr, data_write, sdram_wrmask
    );
endinterface

// File: rtl/jtframe_ram1_nslots.sv
// N-slot SDRAM bank arbiter: one-entry cache per slot, slot 0 read/write, others read-only.
// Misses go to the controller one at a time; fixed-priority or round-robin grant.
module jtframe_ram1_nslots #(
    parameter int                         SDRAMW      = 22,
    parameter int                         NSLOTS      = 4,
    parameter int                         AW          = 22,
    parameter int                         RR          = 0,
    parameter logic [NSLOTS*SDRAMW-1:0]   SLOT_OFFSET = '0
) (
    input logic                  clk,
    input logic                  rst_n,
    jtframe_ram1_nslots_if.slave bus
);
    localparam int SW = $clog2(NSLOTS);

    typedef enum logic { ST_IDLE, ST_WAIT } state_t;

    state_t                       state_q, state_d;
    logic [SW-1:0]                sel_q, sel_d, last_q, last_d;
    logic                         rd_q, rd_d, wr_q, wr_d, opwr_q, opwr_d, wdone_q, wdone_d;
    logic [SDRAMW-1:0]            addr_q, addr_d;
    logic [15:0]                  dwrite_q, dwrite_d;
    logic [1:0]                   wmask_q, wmask_d;
    logic [NSLOTS-1:0]            valid_q, valid_d;
    logic [NSLOTS-1:0][AW-1:0]    tag_q, tag_d;
    logic [NSLOTS-1:0][15:0]      data_q, data_d;

    logic [NSLOTS-1:0]            hit, req;
    logic                         wr_ok;
    logic [SW-1:0]                win;
    int                           start;

    function automatic logic [SW-1:0] pick(input logic [NSLOTS-1:0] r, input int first);
        logic [SW-1:0] w;
        logic          found;
        int            idx;
        w     = '0;
        found = 1'b0;
        for (int k = 0; k < NSLOTS; k++) begin
            idx = (first + k) % NSLOTS;
            if (!found && r[idx]) begin
                w     = idx[SW-1:0];
                found = 1'b1;
            end
        end
        return w;
    endfunction

    always_comb begin
        hit = '0;
        req = '0;
        for (int i = 0; i < NSLOTS; i++) begin
            hit[i] = bus.slot_cs[i] & valid_q[i] & (bus.slot_addr[i*AW +: AW] == tag_q[i]);
        end
        hit[0] = hit[0] & ~bus.slot0_wen;
        // The slot being served must not re-request against its own stale cache line
        for (int i = 0; i < NSLOTS; i++) begin
            req[i] = bus.slot_cs[i] & ~hit[i] & ~(state_q == ST_WAIT && int'(sel_q) == i);
        end
        req[0] = req[0] & ~wdone_q;
    end

    assign wr_ok            = wdone_q & bus.slot_cs[0] & bus.slot0_wen;
    assign bus.slot_ok      = hit | {{(NSLOTS-1){1'b0}}, wr_ok};
    assign bus.slot_dout    = data_q;
    assign bus.sdram_rd     = rd_q;
    assign bus.sdram_wr     = wr_q;
    assign bus.sdram_addr   = addr_q;
    assign bus.data_write   = dwrite_q;
    assign bus.sdram_wrmask = wmask_q;

    assign start = (RR != 0) ? (int'(last_q) + 1) % NSLOTS : 0;
    assign win   = pick(req, start);

    always_comb begin
        logic grant;
        state_d  = state_q;
        sel_d    = sel_q;
        last_d   = last_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        opwr_d   = opwr_q;
        addr_d   = addr_q;
        dwrite_d = dwrite_q;
        wmask_d  = wmask_q;
        valid_d  = valid_q;
        tag_d    = tag_q;
        data_d   = data_q;
        grant    = 1'b0;
        wdone_d  = wdone_q & bus.slot_cs[0] & (bus.slot_addr[0 +: AW] == tag_q[0]);

        if (bus.sdram_ack) begin
            rd_d = 1'b0;
            wr_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: grant = |req;
            ST_WAIT: begin
                if (bus.data_rdy) begin
                    if (opwr_q) begin
                        valid_d[0] = 1'b0;
                        wdone_d    = 1'b1;
                    end else begin
                        data_d[sel_q]  = bus.data_read;
                        valid_d[sel_q] = 1'b1;
                    end
                    grant = |req;
                    if (!grant) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (grant) begin
            state_d     = ST_WAIT;
            sel_d       = win;
            last_d      = win;
            addr_d      = SLOT_OFFSET[int'(win)*SDRAMW +: SDRAMW]
                        + SDRAMW'(bus.slot_addr[int'(win)*AW +: AW]);
            tag_d[win]   = bus.slot_addr[int'(win)*AW +: AW];
            valid_d[win] = 1'b0;
            if (win == '0 && bus.slot0_wen) begin
                rd_d     = 1'b0;
                wr_d     = 1'b1;
                opwr_d   = 1'b1;
                dwrite_d = bus.slot0_din;
                wmask_d  = bus.slot0_wrmask;
            end else begin
                rd_d   = 1'b1;
                wr_d   = 1'b0;
                opwr_d = 1'b0;
            end
        end

        // Invalidation takes precedence over a same-cycle fill
        valid_d = valid_d & ~bus.slot_clr;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            last_q   <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            opwr_q   <= 1'b0;
            wdone_q  <= 1'b0;
            addr_q   <= '0;
            dwrite_q <= '0;
            wmask_q  <= 2'b11;
            valid_q  <= '0;
            tag_q    <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            opwr_q   <= opwr_d;
            wdone_q  <= wdone_d;
            addr_q   <= addr_d;
            dwrite_q <= dwrite_d;
            wmask_q  <= wmask_d;
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            data_q   <= data_d;
        end
    end

`ifdef JTFRAME_SDRAM_CHECK
    always @(posedge clk) begin
        if (rst_n && state_q == ST_IDLE && bus.data_rdy) begin
            $display("jtframe_ram1_nslots: data_rdy received with no transfer in progress");
            $finish;
        end
    end
`endif
endmodule

// File: tb/tb_jtframe_ram1_nslots.sv
// Directed bench for jtframe_ram1_nslots: one fixed-priority and one round-robin instance.
module tb_jtframe_ram1_nslots;
    localparam int SDRAMW = 22;
    localparam int NSLOTS = 4;
    localparam int AW     = 16;
    localparam logic [NSLOTS*SDRAMW-1:0] OFFS = {22'h300000, 22'h200000, 22'h100000, 22'h000000};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    jtframe_ram1_nslots_if #(.SDRAMW(SDRAMW), .NSLOTS(NSLOTS), .AW(AW)) if0 ();
    jtframe_ram1_nslots_if #(.SDRAMW(SDRAMW), .NSLOTS(NSLOTS), .AW(AW)) if1 ();

    jtframe_ram1_nslots #(.SDRAMW(SDRAMW), .NSLOTS(NSLOTS), .AW(AW), .RR(0), .SLOT_OFFSET(OFFS))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    jtframe_ram1_nslots #(.SDRAMW(SDRAMW), .NSLOTS(NSLOTS), .AW(AW), .RR(1), .SLOT_OFFSET(OFFS))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if0.slot_addr = '0; if0.slot_cs = '0; if0.slot_clr = '0; if0.slot0_wen = 0;
        if0.slot0_din = '0; if0.slot0_wrmask = 2'b11; if0.sdram_ack = 0; if0.data_rdy = 0; if0.data_read = '0;
        if1.slot_addr = '0; if1.slot_cs = '0; if1.slot_clr = '0; if1.slot0_wen = 0;
        if1.slot0_din = '0; if1.slot0_wrmask = 2'b11; if1.sdram_ack = 0; if1.data_rdy = 0; if1.data_read = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick(3);
        checks++; if (if0.sdram_rd !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b want 0", if0.sdram_rd); end
        checks++; if (if0.sdram_wr !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b want 0", if0.sdram_wr); end
        checks++; if (if0.sdram_wrmask !== 2'b11) begin errors++; $display("FAIL reset_wrmask: got %b want 11", if0.sdram_wrmask); end
        checks++; if (if0.slot_ok !== 4'b0000) begin errors++; $display("FAIL reset_ok: got %b want 0000", if0.slot_ok); end
        checks++; if (if0.sdram_addr !== 22'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", if0.sdram_addr); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_miss_hit();
        if0.slot_addr[1*AW +: AW] = 16'h0010;
        if0.slot_cs[1] = 1'b1;
        tick();
        checks++; if (if0.sdram_rd !== 1'b1) begin errors++; $display("FAIL miss_rd: got %b want 1", if0.sdram_rd); end
        checks++; if (if0.sdram_addr !== 22'h100010) begin errors++; $display("FAIL miss_addr: got %h want 100010", if0.sdram_addr); end
        checks++; if (if0.slot_ok[1] !== 1'b0) begin errors++; $display("FAIL miss_ok_early: got %b want 0", if0.slot_ok[1]); end
        if0.sdram_ack = 1'b1;
        tick();
        if0.sdram_ack = 1'b0;
        checks++; if (if0.sdram_rd !== 1'b0) begin errors++; $display("FAIL ack_drops_rd: got %b want 0", if0.sdram_rd); end
        if0.data_read = 16'hBEEF; if0.data_rdy = 1'b1;
        tick();
        if0.data_rdy = 1'b0;
        checks++; if (if0.slot_ok[1] !== 1'b1) begin errors++; $display("FAIL fill_ok: got %b want 1", if0.slot_ok[1]); end
        checks++; if (if0.slot_dout[1*16 +: 16] !== 16'hBEEF) begin errors++; $display("FAIL fill_dout: got %h want beef", if0.slot_dout[1*16 +: 16]); end
        if0.slot_cs[1] = 1'b0;
        tick();
        if0.slot_cs[1] = 1'b1;
        #1;
        checks++; if (if0.slot_ok[1] !== 1'b1) begin errors++; $display("FAIL hit_ok: got %b want 1", if0.slot_ok[1]); end
        tick(2);
        checks++; if (if0.sdram_rd !== 1'b0) begin errors++; $display("FAIL hit_no_rd: got %b want 0", if0.sdram_rd); end
        if0.slot_cs[1] = 1'b0;
        tick();
    endtask

    task automatic test_write();
        if0.slot_addr[0 +: AW] = 16'h0005;
        if0.slot0_din = 16'h1234; if0.slot0_wrmask = 2'b10; if0.slot0_wen = 1'b1;
        if0.slot_cs[0] = 1'b1;
        tick();
        checks++; if (if0.sdram_wr !== 1'b1 || if0.sdram_rd !== 1'b0) begin errors++; $display("FAIL wr_cmd: got wr=%b rd=%b want wr=1 rd=0", if0.sdram_wr, if0.sdram_rd); end
        checks++; if (if0.data_write !== 16'h1234) begin errors++; $display("FAIL wr_data: got %h want 1234", if0.data_write); end
        checks++; if (if0.sdram_wrmask !== 2'b10) begin errors++; $display("FAIL wr_mask: got %b want 10", if0.sdram_wrmask); end
        checks++; if (if0.sdram_addr !== 22'h000005) begin errors++; $display("FAIL wr_addr: got %h want 000005", if0.sdram_addr); end
        checks++; if (if0.slot_ok[0] !== 1'b0) begin errors++; $display("FAIL wr_ok_early: got %b want 0", if0.slot_ok[0]); end
        if0.sdram_ack = 1'b1;
        tick();
        if0.sdram_ack = 1'b0;
        checks++; if (if0.sdram_wr !== 1'b0) begin errors++; $display("FAIL wr_ack: got %b want 0", if0.sdram_wr); end
        if0.data_rdy = 1'b1;
        tick();
        if0.data_rdy = 1'b0;
        checks++; if (if0.slot_ok[0] !== 1'b1) begin errors++; $display("FAIL wr_done_ok: got %b want 1", if0.slot_ok[0]); end
        tick();
        checks++; if (if0.slot_ok[0] !== 1'b1 || if0.sdram_wr !== 1'b0) begin errors++; $display("FAIL wr_done_hold: got ok=%b wr=%b want ok=1 wr=0", if0.slot_ok[0], if0.sdram_wr); end
        if0.slot_cs[0] = 1'b0;
        #1;
        checks++; if (if0.slot_ok[0] !== 1'b0) begin errors++; $display("FAIL wr_cs_fall: got %b want 0", if0.slot_ok[0]); end
        tick();
        if0.slot0_wen = 1'b0; if0.slot_cs[0] = 1'b1;
        tick();
        checks++; if (if0.sdram_rd !== 1'b1 || if0.sdram_addr !== 22'h000005) begin errors++; $display("FAIL rd_after_wr: got rd=%b addr=%h want rd=1 addr=000005", if0.sdram_rd, if0.sdram_addr); end
        if0.sdram_ack = 1'b1; if0.data_rdy = 1'b1; if0.data_read = 16'h5555;
        tick();
        if0.sdram_ack = 1'b0; if0.data_rdy = 1'b0;
        checks++; if (if0.slot_ok[0] !== 1'b1 || if0.slot_dout[15:0] !== 16'h5555) begin errors++; $display("FAIL rd_after_wr_fill: got ok=%b dout=%h want ok=1 dout=5555", if0.slot_ok[0], if0.slot_dout[15:0]); end
        if0.slot_cs[0] = 1'b0;
        tick();
    endtask

    task automatic test_priority();
        if0.slot_addr[1*AW +: AW] = 16'h0020;
        if0.slot_addr[2*AW +: AW] = 16'h0030;
        if0.slot_addr[3*AW +: AW] = 16'h0040;
        if0.slot_cs = 4'b1110;
        tick();
        checks++; if (if0.sdram_addr !== 22'h100020 || if0.sdram_rd !== 1'b1) begin errors++; $display("FAIL prio_g1: got addr=%h rd=%b want 100020 1", if0.sdram_addr, if0.sdram_rd); end
        if0.sdram_ack = 1'b1; if0.data_rdy = 1'b1; if0.data_read = 16'h1111;
        tick();
        checks++; if (if0.sdram_addr !== 22'h200030 || if0.sdram_rd !== 1'b1) begin errors++; $display("FAIL prio_g2: got addr=%h rd=%b want 200030 1", if0.sdram_addr, if0.sdram_rd); end
        checks++; if (if0.slot_dout[1*16 +: 16] !== 16'h1111 || if0.slot_ok[1] !== 1'b1) begin errors++; $display("FAIL prio_fill1: got dout=%h ok=%b want 1111 1", if0.slot_dout[1*16 +: 16], if0.slot_ok[1]); end
        if0.data_read = 16'h2222;
        tick();
        checks++; if (if0.sdram_addr !== 22'h300040 || if0.sdram_rd !== 1'b1) begin errors++; $display("FAIL prio_g3: got addr=%h rd=%b want 300040 1", if0.sdram_addr, if0.sdram_rd); end
        if0.data_read = 16'h3333;
        tick();
        if0.sdram_ack = 1'b0; if0.data_rdy = 1'b0;
        checks++; if (if0.sdram_rd !== 1'b0 || if0.slot_ok !== 4'b1110) begin errors++; $display("FAIL prio_done: got rd=%b ok=%b want 0 1110", if0.sdram_rd, if0.slot_ok); end
        checks++; if (if0.slot_dout[3*16 +: 16] !== 16'h3333) begin errors++; $display("FAIL prio_fill3: got %h want 3333", if0.slot_dout[3*16 +: 16]); end
        if0.slot_cs = 4'b0000;
        tick();
    endtask

    task automatic test_round_robin();
        if1.slot_addr[1*AW +: AW] = 16'h0020;
        if1.slot_addr[2*AW +: AW] = 16'h0030;
        if1.slot_addr[3*AW +: AW] = 16'h0040;
        if1.slot_cs = 4'b1110;
        tick();
        checks++; if (if1.sdram_addr !== 22'h100020) begin errors++; $display("FAIL rr_g1: got %h want 100020", if1.sdram_addr); end
        if1.sdram_ack = 1'b1; if1.data_rdy = 1'b1; if1.data_read = 16'hA001;
        tick();
        checks++; if (if1.sdram_addr !== 22'h200030) begin errors++; $display("FAIL rr_g2: got %h want 200030", if1.sdram_addr); end
        if1.slot_addr[1*AW +: AW] = 16'h0050;
        if1.data_read = 16'hA002;
        tick();
        checks++; if (if1.sdram_addr !== 22'h300040) begin errors++; $display("FAIL rr_g3: got %h want 300040", if1.sdram_addr); end
        if1.data_read = 16'hA003;
        tick();
        checks++; if (if1.sdram_addr !== 22'h100050 || if1.sdram_rd !== 1'b1) begin errors++; $display("FAIL rr_g4: got addr=%h rd=%b want 100050 1", if1.sdram_addr, if1.sdram_rd); end
        if1.data_read = 16'hA004;
        tick();
        if1.sdram_ack = 1'b0; if1.data_rdy = 1'b0;
        checks++; if (if1.slot_ok !== 4'b1110 || if1.slot_dout[1*16 +: 16] !== 16'hA004) begin errors++; $display("FAIL rr_done: got ok=%b dout1=%h want 1110 a004", if1.slot_ok, if1.slot_dout[1*16 +: 16]); end
        if1.slot_cs = 4'b0000;
        tick();
    endtask

    task automatic test_clr_collision();
        if0.slot_addr[2*AW +: AW] = 16'h0031;
        if0.slot_cs[2] = 1'b1;
        tick();
        checks++; if (if0.sdram_addr !== 22'h200031) begin errors++; $display("FAIL clr_req: got %h want 200031", if0.sdram_addr); end
        if0.sdram_ack = 1'b1;
        tick();
        if0.sdram_ack = 1'b0;
        if0.data_rdy = 1'b1; if0.data_read = 16'h7777; if0.slot_clr[2] = 1'b1;
        tick();
        if0.data_rdy = 1'b0; if0.slot_clr[2] = 1'b0;
        checks++; if (if0.slot_ok[2] !== 1'b0) begin errors++; $display("FAIL clr_wins: got %b want 0", if0.slot_ok[2]); end
        tick();
        checks++; if (if0.sdram_rd !== 1'b1 || if0.sdram_addr !== 22'h200031) begin errors++; $display("FAIL clr_rereq: got rd=%b addr=%h want 1 200031", if0.sdram_rd, if0.sdram_addr); end
        if0.sdram_ack = 1'b1; if0.data_rdy = 1'b1; if0.data_read = 16'h8888;
        tick();
        if0.sdram_ack = 1'b0; if0.data_rdy = 1'b0;
        checks++; if (if0.slot_ok[2] !== 1'b1 || if0.slot_dout[2*16 +: 16] !== 16'h8888) begin errors++; $display("FAIL clr_refill: got ok=%b dout=%h want 1 8888", if0.slot_ok[2], if0.slot_dout[2*16 +: 16]); end
        if0.slot_cs[2] = 1'b0;
        tick();
    endtask

    task automatic test_reset_in_wait();
        if0.slot_addr[3*AW +: AW] = 16'h0044;
        if0.slot_cs[3] = 1'b1;
        tick();
        checks++; if (if0.sdram_rd !== 1'b1 || if0.sdram_addr !== 22'h300044) begin errors++; $display("FAIL rw_req: got rd=%b addr=%h want 1 300044", if0.sdram_rd, if0.sdram_addr); end
        rst_n = 1'b0; if0.slot_cs[3] = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (if0.sdram_rd !== 1'b0) begin errors++; $display("FAIL rw_rd_cleared: got %b want 0", if0.sdram_rd); end
        if0.data_rdy = 1'b1; if0.data_read = 16'hDEAD;
        tick();
        if0.data_rdy = 1'b0;
        if0.slot_cs[3] = 1'b1;
        #1;
        checks++; if (if0.slot_ok[3] !== 1'b0 || if0.slot_dout[3*16 +: 16] !== 16'h0000) begin errors++; $display("FAIL rw_no_update: got ok=%b dout=%h want 0 0000", if0.slot_ok[3], if0.slot_dout[3*16 +: 16]); end
        checks++; if (if0.sdram_rd !== 1'b0) begin errors++; $display("FAIL rw_rd_idle: got %b want 0", if0.sdram_rd); end
        if0.slot_cs[3] = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_miss_hit();
        test_write();
        test_priority();
        test_round_robin();
        test_clr_collision();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
